// File: rtl/memory_packet_reader.sv
// Streams LEN consecutive memory words starting at BASE onto a valid/ready word stream.
// Optional trailing checksum word: define MEMORY_PACKET_READER_CHECKSUM_EN.
module memory_packet_reader #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [LEN_WIDTH-1:0]        length,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_enable_out,
  output logic                        mem_wb_out,
  output logic [ADDR_WIDTH-1:0]       mem_addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [MEMORY_BUS_WIDTH-1:0] tx_data,
  output logic                        tx_last,
  output logic [2:0]                  dbg_state
);

  // Stream handshake: a word moves when tx_valid && tx_ready; while tx_valid is
  // high and tx_ready is low, tx_data/tx_last/tx_valid are held unchanged.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_CSUM   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [ADDR_WIDTH-1:0]       r_mem_addr;
  logic [LEN_WIDTH-1:0]        r_remain;
  logic                        r_tx_valid;
  logic                        r_tx_last;
  logic [MEMORY_BUS_WIDTH-1:0] r_tx_data;
  logic                        w_free;
  logic                        w_issue;
  logic                        w_issue_last;
  logic                        w_accept_start;
  logic                        w_load_csum;

  assign w_free         = !r_tx_valid || tx_ready;
  assign w_issue        = (r_state == ST_READ) && (r_remain != '0) && w_free;
  assign w_issue_last   = (r_remain == LEN_WIDTH'(1));
  assign w_accept_start = (r_state == ST_IDLE) && start;

`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
  logic [MEMORY_BUS_WIDTH-1:0] r_sum;
  assign w_load_csum = (r_state == ST_CSUM) && w_free;
`else
  assign w_load_csum = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) w_next = ST_READ;
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
          else              w_next = ST_CSUM;
`else
          else              w_next = ST_FINISH;
`endif
        end
      end
      ST_READ: begin
        if (w_issue && w_issue_last) begin
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
          w_next = ST_CSUM;
`else
          w_next = ST_DRAIN;
`endif
        end
      end
      ST_CSUM:   if (w_load_csum) w_next = ST_DRAIN;
      ST_DRAIN:  if (r_tx_valid && tx_ready && r_tx_last) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state == ST_READ) || (r_state == ST_CSUM) || (r_state == ST_DRAIN);
    done           = (r_state == ST_FINISH);
    mem_enable_out = w_issue;
    // Live address only while a read is issued; otherwise the last one used.
    mem_addr_out   = w_issue ? r_addr : r_mem_addr;
    mem_wb_out     = 1'b0;
    mem_data_out   = '0;
    tx_valid       = r_tx_valid;
    tx_last        = r_tx_last;
    tx_data        = r_tx_data;
    dbg_state      = r_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_remain   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_tx_data  <= '0;
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      if (w_accept_start) begin
        r_addr   <= base_addr;
        r_remain <= length;
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
        r_sum    <= '0;
`endif
      end
      if (w_issue) begin
        r_addr     <= r_addr + ADDR_WIDTH'(1);
        r_remain   <= r_remain - LEN_WIDTH'(1);
        r_mem_addr <= r_addr;
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
        r_sum      <= r_sum + mem_data_in;
`endif
      end
      if (w_issue) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= mem_data_in;
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
        r_tx_last  <= 1'b0;
`else
        r_tx_last  <= w_issue_last;
`endif
      end else if (w_load_csum) begin
        r_tx_valid <= 1'b1;
        r_tx_last  <= 1'b1;
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
        r_tx_data  <= r_sum;
`endif
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
        r_tx_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_packet_reader.sv
// Directed bench for memory_packet_reader: latency, back-pressure, zero length,
// address wrap, ignored/aborted starts. Follows MEMORY_PACKET_READER_CHECKSUM_EN if defined.
module tb_memory_packet_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, mem_enable_out, mem_wb_out;
  logic [15:0] mem_addr_out;
  logic [31:0] mem_data_out, mem_data_in;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic [2:0]  dbg_state;

  logic [31:0] mem_model [0:65535];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clock = ~clock;

  assign mem_data_in = mem_model[mem_addr_out];

  memory_packet_reader #(
    .MEMORY_BUS_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Runs one transfer from posedge+1; mode 0: ready always, mode 1: ready 1,0,0,1,0,0...
  task automatic run_xfer(input logic [15:0] base, input logic [15:0] len, input int mode,
                          input bit poke_finish, input string tag);
    logic [32:0] exp_q[$];
    logic [32:0] item;
    logic [31:0] sum;
    logic [31:0] prev_data;
    logic [15:0] exp_addr;
    logic        prev_last, stalled, busy_seen;
    int          reads, words, dones, done_cyc, first_valid, exp_words, budget;
    sum = '0;
    for (int k = 0; k < int'(len); k++) begin
      logic [15:0] a;
      a = base + 16'(k);
      sum = sum + mem_model[a];
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
      exp_q.push_back({1'b0, mem_model[a]});
`else
      exp_q.push_back({(k == int'(len) - 1), mem_model[a]});
`endif
    end
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
    exp_q.push_back({1'b1, sum});
`endif
    exp_words = exp_q.size();
    exp_addr = base; reads = 0; words = 0; dones = 0; done_cyc = -1; first_valid = -1;
    stalled = 1'b0; busy_seen = 1'b0; prev_data = '0; prev_last = 1'b0;
    budget = int'(len) * 4 + 20;
    start = 1'b1; base_addr = base; length = len;
    @(posedge clock); #1;
    start = 1'b0; base_addr = 16'h5555; length = 16'h0003;
    for (int cyc = 0; cyc < budget && dones == 0; cyc++) begin
      tx_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (mem_enable_out) begin
        check({tag, " read_addr"}, mem_addr_out, exp_addr);
        exp_addr = exp_addr + 16'd1;
        reads++;
      end
      if (stalled) begin
        check({tag, " stall_hold"}, {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
        if (!tx_ready) check({tag, " stall_no_read"}, mem_enable_out, 1'b0);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check({tag, " extra_word"}, {tx_last, tx_data}, 33'h0);
        else begin
          item = exp_q.pop_front();
          check({tag, " word"}, {tx_last, tx_data}, item);
        end
        words++;
      end
      if (done) begin
        dones++; done_cyc = cyc;
        check({tag, " busy_at_done"}, {busy, tx_valid}, 2'b00);
        if (poke_finish) begin
          start = 1'b1; base_addr = 16'h0100; length = 16'd2;
        end
      end
      stalled = tx_valid && !tx_ready; prev_data = tx_data; prev_last = tx_last;
      @(posedge clock); #1;
    end
    start = 1'b0;
    check({tag, " done_count"}, dones, 1);
    check({tag, " reads"}, reads, len);
    check({tag, " words"}, words, exp_words);
    if (mode == 0) begin
`ifdef MEMORY_PACKET_READER_CHECKSUM_EN
      check({tag, " done_cycle"}, done_cyc, int'(len) + 2);
      check({tag, " first_valid"}, first_valid, 1);
`else
      check({tag, " done_cycle"}, done_cyc, (len == 0) ? 0 : int'(len) + 1);
      if (len != 0) check({tag, " first_valid"}, first_valid, 1);
      else          check({tag, " busy_never"}, {busy_seen, first_valid != -1}, 2'b00);
`endif
    end
    @(negedge clock);
    check({tag, " idle_after"}, {done, busy, mem_enable_out, tx_valid, dbg_state}, 7'h0);
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = {16'h5A5A ^ 16'(i), 16'(i)};
    mem_model[16'h0010] = 32'hAAAA_0001;
    mem_model[16'h0011] = 32'hBBBB_0002;
    mem_model[16'h0012] = 32'hCCCC_0003;
    mem_model[16'h0013] = 32'hDDDD_0004;
    mem_model[16'h0200] = 32'h0000_0001;
    mem_model[16'h0201] = 32'h0000_0002;
    mem_model[16'h0202] = 32'hFFFF_FFFF;

    // Reset state
    #12;
    check("reset_outputs", {busy, done, mem_enable_out, tx_valid, tx_last, tx_data, mem_addr_out},
          '0);
    check("reset_state", dbg_state, 3'd0);
    check("tied_outputs", {mem_wb_out, mem_data_out}, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    run_xfer(16'h0010, 16'd4, 0, 1'b1, "basic");
    run_xfer(16'h0010, 16'd4, 1, 1'b0, "backpressure");
    run_xfer(16'h0000, 16'd0, 0, 1'b0, "zero_len");
    run_xfer(16'hFFFE, 16'd3, 0, 1'b0, "wrap");
    run_xfer(16'h0200, 16'd3, 0, 1'b0, "sum_words");
    run_xfer(16'h0300, 16'd7, 1, 1'b0, "long_bp");

    // Second start mid-transfer is ignored, then an asynchronous abort
    tx_ready = 1'b1;
    start = 1'b1; base_addr = 16'h0040; length = 16'd8;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("abort_first_read", {mem_enable_out, mem_addr_out}, {1'b1, 16'h0040});
    @(posedge clock); #1;
    start = 1'b1; base_addr = 16'h0080; length = 16'd2;
    @(negedge clock);
    check("abort_word0", {tx_valid, tx_data, mem_addr_out}, {1'b1, mem_model[16'h0040], 16'h0041});
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("restart_ignored", {busy, mem_enable_out, mem_addr_out}, {2'b11, 16'h0042});
    #2 reset = 1'b0;
    #1;
    check("async_reset_out",
          {busy, done, mem_enable_out, tx_valid, tx_last, tx_data, mem_addr_out, dbg_state}, '0);
    @(negedge clock);
    check("reset_no_done", {done, busy, tx_valid}, 3'b000);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_xfer(16'h0020, 16'd5, 1, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_packet_reader.md
Name: memory_packet_reader

Overview:
- Initiator-side engine for the single-word memory port protocol: enable, write-back, address, write data, read data.
- Reads data combinationally in the same cycle as the address.
- On a start command, reads LEN consecutive words from memory starting at BASE and streams them out on a valid/ready word stream with a last marker.
- Sits between a node's dual-port packet memory (one port) and the network-interface transmit path.

Parameters:
MEMORY_BUS_WIDTH, 32, width of memory words and of the output stream data.
ADDR_WIDTH, 16, width of the memory address and the base-address command field.
LEN_WIDTH, 16, width of the length command field (words).

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  command strobe; sampled only in IDLE.
base_addr  input  ADDR_WIDTH  first word address; captured on an accepted start.
length  input  LEN_WIDTH  number of words to read; captured on an accepted start.
busy  output  1  high from the cycle after an accepted start until the transfer completes.
done  output  1  one-cycle pulse when the transfer completes.
mem_enable_out  output  1  memory port enable; high only during read cycles.
mem_wb_out  output  1  write-back strobe; tied 0 (read-only initiator).
mem_addr_out  output  ADDR_WIDTH  memory address.
mem_data_out  output  MEMORY_BUS_WIDTH  memory write data; tied 0.
mem_data_in  input  MEMORY_BUS_WIDTH  memory read data; valid in the same cycle as mem_addr_out.
tx_valid  output  1  output word valid.
tx_ready  input  1  downstream accepts the word when tx_valid && tx_ready.
tx_data  output  MEMORY_BUS_WIDTH  output word.
tx_last  output  1  marks the final word of the transfer; qualified by tx_valid.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, mem_enable_out, tx_valid and tx_last are 0; tx_data and mem_addr_out are 0; counters are cleared.
  - Reset mid-transfer aborts immediately: no done pulse, and any buffered word is dropped.
- States:
  - IDLE: if start=1 and length!=0, capture base/length and go to READ.
  - IDLE: if start=1 and length=0, go to FINISH with no memory access and no tx word.
  - READ:
    - Issue one read per cycle while the remaining count is nonzero and the output register is free.
    - "Free" means tx_valid=0, or tx_valid && tx_ready in this cycle.
    - On each issue: mem_enable_out=1, mem_addr_out=current address; the output register loads mem_data_in at the clock edge; the address increments and the remaining count decrements.
    - When the last read is issued, go to DRAIN.
  - DRAIN: hold until the final word is accepted (tx_valid && tx_ready && tx_last), then go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
- busy is 1 in READ and DRAIN only.
- Start is ignored outside IDLE, including in the FINISH cycle.
- Latency:
  - Start accepted at edge N; the first read is issued in cycle N+1; tx_valid=1 from cycle N+2.
  - With tx_ready held high, one word is delivered per cycle; throughput is 1 word/cycle.
- Output register: one entry. tx_data, tx_last and tx_valid hold stable while tx_valid && !tx_ready.
- tx_last is set on the word loaded by the read issued with remaining count = 1.
- Address arithmetic is modulo 2^ADDR_WIDTH: a read at address all-ones is followed by a read at 0.
- mem_enable_out=0 whenever no read is issued, including back-pressure stalls. mem_addr_out holds its last value when idle.
- Maximum length is 2^LEN_WIDTH-1 words.

Optional Feature:
Macro: MEMORY_PACKET_READER_CHECKSUM_EN
- Defined:
  - A running sum, modulo 2^MEMORY_BUS_WIDTH, of all payload words is kept.
  - After the last payload word is accepted, one extra word carrying the sum is emitted, and tx_last moves to it; no payload word has tx_last=1.
  - The checksum word involves no memory access.
  - done follows acceptance of the checksum word.
  - length=0 emits a single checksum word of 0 with tx_last=1, then done.
- Not defined: no checksum logic; behaviour exactly as above.

Test Plan:
- Reset then start, base=0x0010, length=4, memory 0x10..0x13 = A,B,C,D, tx_ready=1 -> tx words A,B,C,D on 4 consecutive cycles starting 2 cycles after start; tx_last only on D; done pulses once the cycle after D is accepted.
- Same transfer with tx_ready toggling 1,0,0,1,... -> no word lost or duplicated; tx_data stable during stalls; mem_enable_out=0 on stall cycles; reads issued = 4 exactly.
- start with length=0 -> no mem_enable_out, no tx_valid; done one cycle after start; busy never 1.
- base=0xFFFE, length=3 -> reads at 0xFFFE, 0xFFFF, 0x0000.
- Start pulsed again mid-transfer, then reset=0 asserted asynchronously between edges -> second start ignored; on reset all outputs 0 immediately, no done; a new start after reset release runs normally.
- With MEMORY_PACKET_READER_CHECKSUM_EN, words 1,2,0xFFFFFFFF -> tx 1,2,0xFFFFFFFF,0x00000002, tx_last only on 0x00000002.
